// File: rtl/bsg_idiv_req_pkg.sv
// Shared types for the divider requester: FSM state encoding and the registered request record.
// The request record is width-parameterised through a macro so each instance can size it locally.
package bsg_idiv_req_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        ISSUE = 2'b01,
        WAIT  = 2'b10,
        RESP  = 2'b11
    } idiv_req_state_e;

endpackage

// Packages cannot take parameters, so the request struct body is produced per instance.
`define BSG_IDIV_REQ_T(w, tw) \
    struct packed {                \
        logic [(w)-1:0]  dividend;  \
        logic [(w)-1:0]  divisor;   \
        logic            signed_div;\
        logic [(tw)-1:0] tag;       \
        logic            dbz;       \
    }

// File: rtl/bsg_idiv_req_lat_ctr.sv
// Saturating up-counter with synchronous clear (priority) and count enable.
// Latency: count_o reflects the increment one cycle after en_i; no backpressure, holds at all-ones.
module bsg_idiv_req_lat_ctr #(
    parameter int width_p = 8
) (
    input  logic               clk_i,
    input  logic               reset_n_i,
    input  logic               clear_i,
    input  logic               en_i,
    output logic [width_p-1:0] count_o
);

    logic [width_p-1:0] count_r;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            count_r <= '0;
        end else if (clear_i) begin
            count_r <= '0;
        end else if (en_i && (count_r != '1)) begin
            count_r <= count_r + width_p'(1);
        end
    end

    assign count_o = count_r;

endmodule

// File: rtl/bsg_idiv_requester.sv
// Requester between a client and an iterative divider: one tagged op in flight, returns q/r/tag/dbz/latency.
// Latency: accept -> issue -> divider wait -> RESP; lat_o counts ISSUE+WAIT cycles (saturating), one idle bubble per op.
// Backpressure: ready_o low while busy; div_v_o held until div_ready_i; results held until yumi_i. Option: BSG_IDIV_REQ_DBZ_BYPASS_EN.
module bsg_idiv_requester
    import bsg_idiv_req_pkg::*;
#(
    parameter int width_p     = 64,
    parameter int tag_width_p = 4,
    parameter int lat_width_p = 8
) (
    input  logic                   clk_i,
    input  logic                   reset_n_i,

    input  logic                   v_i,
    output logic                   ready_o,
    input  logic [width_p-1:0]     dividend_i,
    input  logic [width_p-1:0]     divisor_i,
    input  logic                   signed_div_i,
    input  logic [tag_width_p-1:0] tag_i,

    output logic                   div_v_o,
    input  logic                   div_ready_i,
    output logic [width_p-1:0]     div_dividend_o,
    output logic [width_p-1:0]     div_divisor_o,
    output logic                   div_signed_o,

    input  logic                   div_v_i,
    input  logic [width_p-1:0]     div_quotient_i,
    input  logic [width_p-1:0]     div_remainder_i,
    output logic                   div_yumi_o,

    output logic                   v_o,
    output logic [width_p-1:0]     quotient_o,
    output logic [width_p-1:0]     remainder_o,
    output logic [tag_width_p-1:0] tag_o,
    output logic                   dbz_o,
    output logic [lat_width_p-1:0] lat_o,
    input  logic                   yumi_i
);

    typedef `BSG_IDIV_REQ_T(width_p, tag_width_p) req_t;

    idiv_req_state_e    state_r, state_n;
    req_t               req_r;
    logic [width_p-1:0] quotient_r, remainder_r;
    logic               accept, divisor_zero, bypass, lat_en;

    assign accept       = (state_r == IDLE) & v_i;
    assign divisor_zero = (divisor_i == '0);

`ifdef BSG_IDIV_REQ_DBZ_BYPASS_EN
    // Zero divisor is answered locally with RISC-V results; the divider never sees it.
    assign bypass = divisor_zero;
`else
    assign bypass = 1'b0;
`endif

    always_comb begin
        state_n = state_r;
        case (state_r)
            IDLE:    if (v_i)         state_n = bypass ? RESP : ISSUE;
            ISSUE:   if (div_ready_i) state_n = WAIT;
            WAIT:    if (div_v_i)     state_n = RESP;
            RESP:    if (yumi_i)      state_n = IDLE;
            default:                  state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_r     <= IDLE;
            req_r       <= '0;
            quotient_r  <= '0;
            remainder_r <= '0;
        end else begin
            state_r <= state_n;
            if (accept) begin
                req_r <= '{dividend:   dividend_i,
                           divisor:    divisor_i,
                           signed_div: signed_div_i,
                           tag:        tag_i,
                           dbz:        divisor_zero};
            end
            if (accept && bypass) begin
                quotient_r  <= '1;
                remainder_r <= dividend_i;
            end else if ((state_r == WAIT) && div_v_i) begin
                quotient_r  <= div_quotient_i;
                remainder_r <= div_remainder_i;
            end
        end
    end

    assign lat_en = (state_r == ISSUE) || (state_r == WAIT);

    bsg_idiv_req_lat_ctr #(
        .width_p (lat_width_p)
    ) u_lat_ctr (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .clear_i   (accept),
        .en_i      (lat_en),
        .count_o   (lat_o)
    );

    assign ready_o        = (state_r == IDLE);
    assign div_v_o        = (state_r == ISSUE);
    assign div_dividend_o = req_r.dividend;
    assign div_divisor_o  = req_r.divisor;
    assign div_signed_o   = req_r.signed_div;
    // Divider results are only consumed while we are actually waiting for one.
    assign div_yumi_o     = (state_r == WAIT) & div_v_i;

    assign v_o         = (state_r == RESP);
    assign quotient_o  = quotient_r;
    assign remainder_o = remainder_r;
    assign tag_o       = req_r.tag;
    assign dbz_o       = req_r.dbz;

endmodule
